// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract unit with valid/ready handshake on both sides.
// Register cuts land every PIPE_EVERY prefix levels; a sideband tag travels with each operation.
module ks_adder_pipe #(
    parameter int WIDTH      = 64,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);
    localparam int L    = $clog2(WIDTH);
    localparam int NCUT = (L - 1) / PIPE_EVERY;
    localparam int LAT  = NCUT + 2;

    // Generate/propagate vectors are WIDTH+1 wide: index 0 carries c0 as the generate of bit -1.
    function automatic logic [2*WIDTH+1:0] prefix_level(input logic [WIDTH:0] g,
                                                        input logic [WIDTH:0] p,
                                                        input int span);
        logic [WIDTH:0] gn;
        logic [WIDTH:0] pn;
        gn = g;
        pn = p;
        for (int j = 0; j <= WIDTH; j++) begin
            if (j >= span) begin
                gn[j] = g[j] | (p[j] & g[j - span]);
                pn[j] = p[j] & p[j - span];
            end
        end
        return {gn, pn};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p0;
    logic             c0;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;
    assign p0    = a ^ b_eff;

    logic [LAT-1:0] v;
    logic [LAT-1:0] v_src;
    logic [LAT:0]   rdy;

    assign v_src = {v[LAT-2:0], in_valid};

    // Ready ripples back from the consumer; an empty stage always accepts.
    always_comb begin
        rdy      = '0;
        rdy[LAT] = out_ready;
        for (int s = LAT - 1; s >= 0; s--) begin
            rdy[s] = !v[s] || rdy[s+1];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[LAT-1];

    logic [NCUT:0][WIDTH:0]   st_g;
    logic [NCUT:0][WIDTH:0]   st_p;
    logic [NCUT:0][WIDTH-1:0] st_po;
    logic [NCUT:0][TAG_W-1:0] st_tag;
    logic [NCUT:0][WIDTH:0]   nx_g;
    logic [NCUT:0][WIDTH:0]   nx_p;
    logic [NCUT:0][WIDTH-1:0] nx_po;
    logic [NCUT:0][TAG_W-1:0] nx_tag;

    assign nx_g[0]   = {a & b_eff, c0};
    assign nx_p[0]   = {p0, 1'b0};
    assign nx_po[0]  = p0;
    assign nx_tag[0] = in_tag;

    genvar k;
    for (k = 1; k <= L; k++) begin : g_lvl
        logic [WIDTH:0] g;
        logic [WIDTH:0] p;
        logic [WIDTH:0] g_src;
        logic [WIDTH:0] p_src;

        if ((k - 1) % PIPE_EVERY == 0) begin : g_from_reg
            assign g_src = st_g[(k-1)/PIPE_EVERY];
            assign p_src = st_p[(k-1)/PIPE_EVERY];
        end else begin : g_from_lvl
            assign g_src = g_lvl[k-1].g;
            assign p_src = g_lvl[k-1].p;
        end

        assign {g, p} = prefix_level(g_src, p_src, 2 ** (k - 1));

        if ((k % PIPE_EVERY == 0) && (k < L)) begin : g_cut
            assign nx_g[k/PIPE_EVERY]   = g;
            assign nx_p[k/PIPE_EVERY]   = p;
            assign nx_po[k/PIPE_EVERY]  = st_po[k/PIPE_EVERY-1];
            assign nx_tag[k/PIPE_EVERY] = st_tag[k/PIPE_EVERY-1];
        end
    end

    logic [WIDTH:0]   fin_g;
    logic [WIDTH:0]   fin_p;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;
    logic             unused_fin_p;

    assign fin_g = g_lvl[L].g;
    assign fin_p = g_lvl[L].p;

    // The top group spans bits 0..WIDTH-1 only, so c0 is folded in here for the carry-out.
    assign sum_c        = st_po[NCUT] ^ fin_g[WIDTH-1:0];
    assign cout_c       = fin_g[WIDTH] | (fin_p[WIDTH] & fin_g[0]);
    assign ovf_c        = cout_c ^ fin_g[WIDTH-1];
    assign unused_fin_p = ^fin_p[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v       <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            out_tag <= '0;
        end else begin
            for (int s = 0; s < LAT; s++) begin
                if (rdy[s]) v[s] <= v_src[s];
            end
            for (int s = 0; s <= NCUT; s++) begin
                if (rdy[s] && v_src[s]) begin
                    st_g[s]   <= nx_g[s];
                    st_p[s]   <= nx_p[s];
                    st_po[s]  <= nx_po[s];
                    st_tag[s] <= nx_tag[s];
                end
            end
            if (rdy[LAT-1] && v_src[LAT-1]) begin
                sum     <= sum_c;
                cout    <= cout_c;
                ovf     <= ovf_c;
                out_tag <= st_tag[NCUT];
            end
        end
    end

endmodule
